// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   Operand-forwarding and load-use hazard control for the 16-bit, 5-stage CPU.
//   The instruction in ID is decoded and compared with the destinations of
//   the instructions now in EX and MEM. The resulting selects are registered,
//   so they reach the EX-stage operand formatter together with the instruction.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   instr_ID  ID instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm
//   freeze    global pipeline hold; all state holds
//   flush_ID  squash the ID instruction; a bubble enters EX
//   ForwardA  EX ALU-A select: [1] alu_out_MEM, [0] WriteData, [2] tied 0
//   ForwardB  EX ALU-B select, same encoding
//   ForwardS  EX store-data select: [1] MEM, [0] WB
//   stall     load-use stall (combinational); holds PC and IF/ID
module forward_hazard_unit #(
    parameter bit         R0_HARDWIRED = 1'b1,
    parameter logic [3:0] LD_OPCODE    = 4'b1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_ID,
    input  logic        freeze,
    input  logic        flush_ID,
    output logic [2:0]  ForwardA,
    output logic [2:0]  ForwardB,
    output logic [1:0]  ForwardS,
    output logic        stall
);

    logic [3:0] op, rd, rs, rt;

    logic       id_writes;
    logic       id_is_load;
    logic       use_a, use_b, use_s;
    logic [3:0] src_a, src_b, src_s;

    // Tracked in-flight entries
    logic       ex_valid, ex_writes, ex_is_load;
    logic [3:0] ex_dst;
    logic       mem_valid, mem_writes;
    logic [3:0] mem_dst;

    logic [1:0] fwd_a_q, fwd_b_q, fwd_s_q;

    logic       a_ex, b_ex, s_ex, a_mem, b_mem, s_mem;
    logic [1:0] sel_a, sel_b, sel_s;
    logic       load_hit;

    assign op = instr_ID[15:12];
    assign rd = instr_ID[11:8];
    assign rs = instr_ID[7:4];
    assign rt = instr_ID[3:0];

    function automatic logic hits(input logic [3:0] src, input logic v,
                                  input logic w, input logic [3:0] dst);
        return v && w && (src == dst) && !(R0_HARDWIRED && (dst == 4'd0));
    endfunction

    always_comb begin
        id_writes  = 1'b0;
        id_is_load = (op == LD_OPCODE);
        use_a      = 1'b0;
        use_b      = 1'b0;
        use_s      = 1'b0;
        src_a      = rs;
        src_b      = rt;
        src_s      = rd;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
                id_writes = 1'b1;
                use_a     = 1'b1;
                use_b     = 1'b1;
            end
            // shifts take an immediate in [3:0]
            4'b0100, 4'b0101, 4'b0110: begin
                id_writes = 1'b1;
                use_a     = 1'b1;
            end
            4'b1000: begin
                id_writes = 1'b1;
                use_a     = 1'b1;
            end
            4'b1001: begin
                use_a = 1'b1;
                use_s = 1'b1;
            end
            // lhb/llb merge into the old rd value, which rides on ALU-A
            4'b1010, 4'b1011: begin
                id_writes = 1'b1;
                use_a     = 1'b1;
                src_a     = rd;
            end
            4'b1101: use_a = 1'b1;
            4'b1110: id_writes = 1'b1;
            default: ;
        endcase
        // a non-default load opcode still writes rd
        if (id_is_load) id_writes = 1'b1;
    end

    always_comb begin
        a_ex  = use_a && hits(src_a, ex_valid, ex_writes, ex_dst);
        b_ex  = use_b && hits(src_b, ex_valid, ex_writes, ex_dst);
        s_ex  = use_s && hits(src_s, ex_valid, ex_writes, ex_dst);
        a_mem = use_a && hits(src_a, mem_valid, mem_writes, mem_dst);
        b_mem = use_b && hits(src_b, mem_valid, mem_writes, mem_dst);
        s_mem = use_s && hits(src_s, mem_valid, mem_writes, mem_dst);

        // newest producer wins; a load in EX cannot forward from MEM next cycle
        sel_a = (a_ex && !ex_is_load) ? 2'b10 : (a_mem ? 2'b01 : 2'b00);
        sel_b = (b_ex && !ex_is_load) ? 2'b10 : (b_mem ? 2'b01 : 2'b00);
        sel_s = (s_ex && !ex_is_load) ? 2'b10 : (s_mem ? 2'b01 : 2'b00);

        load_hit = ex_is_load && (a_ex || b_ex || s_ex);
        stall    = load_hit && !flush_ID && !freeze;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_writes  <= 1'b0;
            ex_is_load <= 1'b0;
            ex_dst     <= 4'd0;
            mem_valid  <= 1'b0;
            mem_writes <= 1'b0;
            mem_dst    <= 4'd0;
            fwd_a_q    <= 2'b00;
            fwd_b_q    <= 2'b00;
            fwd_s_q    <= 2'b00;
        end else if (!freeze) begin
            mem_valid  <= ex_valid;
            mem_writes <= ex_writes;
            mem_dst    <= ex_dst;
            if (flush_ID || stall) begin
                ex_valid   <= 1'b0;
                ex_writes  <= 1'b0;
                ex_is_load <= 1'b0;
                ex_dst     <= 4'd0;
                fwd_a_q    <= 2'b00;
                fwd_b_q    <= 2'b00;
                fwd_s_q    <= 2'b00;
            end else begin
                ex_valid   <= 1'b1;
                ex_writes  <= id_writes;
                ex_is_load <= id_is_load;
                ex_dst     <= rd;
                fwd_a_q    <= sel_a;
                fwd_b_q    <= sel_b;
                fwd_s_q    <= sel_s;
            end
        end
    end

    assign ForwardA = {1'b0, fwd_a_q};
    assign ForwardB = {1'b0, fwd_b_q};
    assign ForwardS = fwd_s_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_ID;
    logic        freeze;
    logic        flush_ID;
    logic [2:0]  ForwardA, ForwardB;
    logic [1:0]  ForwardS;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_q[$];
    logic       stall_q[$];

    // reference pipeline: the instruction words sitting in EX and MEM
    bit          m_ex_v, m_mem_v;
    logic [15:0] m_ex_i, m_mem_i;
    logic [7:0]  m_fwd;

    forward_hazard_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr_ID (instr_ID),
        .freeze   (freeze),
        .flush_ID (flush_ID),
        .ForwardA (ForwardA),
        .ForwardB (ForwardB),
        .ForwardS (ForwardS),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    function automatic bit writes(input logic [15:0] ins);
        int o = int'(ins[15:12]);
        return (o <= 8) || o == 10 || o == 11 || o == 14;
    endfunction

    // which register each operand slot reads, -1 when unused
    function automatic int src_reg(input logic [15:0] ins, input int slot);
        int o = int'(ins[15:12]);
        case (slot)
            0: begin
                if (o <= 9 || o == 13) return int'(ins[7:4]);
                if (o == 10 || o == 11) return int'(ins[11:8]);
                return -1;
            end
            1: return (o <= 3 || o == 7) ? int'(ins[3:0]) : -1;
            default: return (o == 9) ? int'(ins[11:8]) : -1;
        endcase
    endfunction

    // 2 = from MEM stage, 1 = from WB stage, 0 = regfile; sets lu on load-use
    function automatic int pick(input int r, inout bit lu);
        if (r < 0 || r == 0) return 0;
        if (m_ex_v && writes(m_ex_i) && int'(m_ex_i[11:8]) == r) begin
            if (m_ex_i[15:12] == 4'b1000) begin
                lu = 1'b1;
                return 0;
            end
            return 2;
        end
        if (m_mem_v && writes(m_mem_i) && int'(m_mem_i[11:8]) == r) return 1;
        return 0;
    endfunction

    task automatic step(input logic [15:0] ins, input bit fl, input bit fz,
                        input bit rn, output bit st);
        int  sa, sb, ss;
        bit  lu;
        @(negedge clk);
        instr_ID = ins;
        flush_ID = fl;
        freeze   = fz;
        rst_n    = rn;
        #1;
        lu = 1'b0;
        sa = pick(src_reg(ins, 0), lu);
        sb = pick(src_reg(ins, 1), lu);
        ss = pick(src_reg(ins, 2), lu);
        st = lu && !fl && !fz;
        stall_q.push_back(st);
        if (!rn) begin
            m_ex_v  = 0;
            m_mem_v = 0;
            m_fwd   = 8'h00;
        end else if (!fz) begin
            m_mem_v = m_ex_v;
            m_mem_i = m_ex_i;
            if (fl || st) begin
                m_ex_v = 0;
                m_fwd  = 8'h00;
            end else begin
                m_ex_v = 1;
                m_ex_i = ins;
                m_fwd  = {3'(sa), 3'(sb), 2'(ss)};
            end
        end
        fwd_q.push_back(m_fwd);
    endtask

    // forward-select monitor: registered outputs after each rising edge
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (fwd_q.size() > 0) begin
                e = fwd_q.pop_front();
                n_checks++;
                if ({ForwardA, ForwardB, ForwardS} !== e) begin
                    n_fail++;
                    $display("FAIL fwd t=%0t instr=%h got A=%b B=%b S=%b exp A=%b B=%b S=%b",
                             $time, instr_ID, ForwardA, ForwardB, ForwardS, e[7:5], e[4:2], e[1:0]);
                end
            end
        end
    end

    // stall monitor: combinational output, sampled mid low phase
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            #3;
            if (stall_q.size() > 0) begin
                e = stall_q.pop_front();
                n_checks++;
                if (stall !== e) begin
                    n_fail++;
                    $display("FAIL stall t=%0t instr=%h got %b exp %b", $time, instr_ID, stall, e);
                end
            end
        end
    end

    localparam logic [15:0] NOP = 16'hF000;

    initial begin
        bit          st;
        logic [15:0] cur;
        bit          fl, fz, rn;
        rst_n    = 1'b0;
        instr_ID = NOP;
        freeze   = 1'b0;
        flush_ID = 1'b0;
        m_ex_v   = 0;
        m_mem_v  = 0;
        m_ex_i   = NOP;
        m_mem_i  = NOP;
        m_fwd    = 8'h00;

        step(NOP, 0, 0, 0, st);
        step(NOP, 0, 0, 0, st);

        // back-to-back
        step(16'h0123, 0, 0, 1, st);
        step(16'h1415, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        // distance two
        step(16'h0123, 0, 0, 1, st);
        step(16'h3678, 0, 0, 1, st);
        step(16'h0591, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        // load-use
        step(16'h8120, 0, 0, 1, st);
        step(16'h0314, 0, 0, 1, st);
        step(16'h0314, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        // store data after LLB, then R0 producer
        step(16'hB5AA, 0, 0, 1, st);
        step(16'h9520, 0, 0, 1, st);
        step(16'h0023, 0, 0, 1, st);
        step(16'h1405, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        // shift immediate, freeze, flush
        step(16'h0123, 0, 0, 1, st);
        step(16'h4712, 0, 0, 1, st);
        step(16'h1415, 0, 1, 1, st);
        step(16'h1415, 0, 1, 1, st);
        step(16'h1415, 0, 1, 1, st);
        step(NOP, 0, 0, 1, st);
        step(16'h0123, 0, 0, 1, st);
        step(16'h1415, 1, 0, 1, st);
        step(16'h0645, 0, 0, 1, st);
        step(16'h0746, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);
        // reset mid-stream with a load in EX and a dependent in ID
        step(16'h8120, 0, 0, 1, st);
        step(16'h0314, 0, 0, 0, st);
        step(16'h0314, 0, 0, 1, st);
        step(NOP, 0, 0, 1, st);

        // randomized traffic on a narrow register range to provoke hazards
        cur = NOP;
        for (int i = 0; i < 800; i++) begin
            fl = ($urandom_range(0, 9) == 0);
            fz = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 49) != 0);
            step(cur, fl, fz, rn, st);
            if (!(st || fz))
                cur = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        end

        step(NOP, 0, 0, 1, st);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (fwd_q.size() != 0 || stall_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got fwd_q=%0d stall_q=%0d exp 0 0", fwd_q.size(), stall_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
